// File: rtl/sdrc_bank_arb_pkg.sv
// Shared definitions for the SDRAM bank arbiter: command and state encodings, default widths.
package sdrc_bank_arb_pkg;

    localparam int SDR_REQ_ID_W = 4;
    localparam int REQ_BW_DEF   = 12;
    localparam int NB_DEF       = 4;

    typedef enum logic [1:0] {
        OP_PRE = 2'd0,
        OP_ACT = 2'd1,
        OP_RD  = 2'd2,
        OP_WR  = 2'd3
    } sdr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Data-transfer commands outrank bank open/close when priority is enabled.
    function automatic logic is_xfr_op(input logic [1:0] cmd);
        return (cmd == OP_RD) || (cmd == OP_WR);
    endfunction

endpackage

// File: rtl/sdrc_bank_arb_if.sv
// Bank-to-arbiter request bus and arbiter-to-xfr_ctl request bus.
interface sdrc_bank_arb_if #(
    parameter int REQ_BW       = sdrc_bank_arb_pkg::REQ_BW_DEF,
    parameter int SDR_REQ_ID_W = sdrc_bank_arb_pkg::SDR_REQ_ID_W,
    parameter int NB           = sdrc_bank_arb_pkg::NB_DEF
);
    logic [NB-1:0]              b2a_req;
    logic [2*NB-1:0]            b2a_cmd;
    logic [12*NB-1:0]           b2a_addr;
    logic [REQ_BW*NB-1:0]       b2a_len;
    logic [SDR_REQ_ID_W*NB-1:0] b2a_id;
    logic [NB-1:0]              b2a_start;
    logic [NB-1:0]              b2a_last;
    logic [NB-1:0]              b2a_wrap;
    logic [NB-1:0]              a2b_ack;

    logic                       a2x_req;
    logic [1:0]                 a2x_cmd;
    logic [1:0]                 a2x_ba;
    logic [11:0]                a2x_addr;
    logic [REQ_BW-1:0]          a2x_len;
    logic [SDR_REQ_ID_W-1:0]    a2x_id;
    logic                       a2x_start;
    logic                       a2x_last;
    logic                       a2x_wrap;
    logic                       x2a_ack;
    logic                       x2a_ref_pend;

    modport slave (
        input  b2a_req, b2a_cmd, b2a_addr, b2a_len, b2a_id, b2a_start, b2a_last, b2a_wrap,
        input  x2a_ack, x2a_ref_pend,
        output a2b_ack,
        output a2x_req, a2x_cmd, a2x_ba, a2x_addr, a2x_len, a2x_id, a2x_start, a2x_last, a2x_wrap
    );

    modport master (
        output b2a_req, b2a_cmd, b2a_addr, b2a_len, b2a_id, b2a_start, b2a_last, b2a_wrap,
        output x2a_ack, x2a_ref_pend,
        input  a2b_ack,
        input  a2x_req, a2x_cmd, a2x_ba, a2x_addr, a2x_len, a2x_id, a2x_start, a2x_last, a2x_wrap
    );
endinterface

// File: rtl/sdrc_rr_pick.sv
// Four-way round-robin picker: first asserted request at or after ptr (mod 4).
module sdrc_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);
    always_comb begin
        valid = |req;
        idx   = ptr;
        // Walk from farthest to nearest so the nearest requester overwrites last.
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                idx = ptr + 2'(k);
            end
        end
    end
endmodule

// File: rtl/sdrc_bank_arb.sv
// Round-robin bank request arbiter feeding xfr_ctl, with lock-until-ack handshake.
// Optional RD/WR-over-PRE/ACT priority selected by `define SDRC_BANK_ARB_RDWR_PRIO_EN.
module sdrc_bank_arb #(
    parameter int REQ_BW       = sdrc_bank_arb_pkg::REQ_BW_DEF,
    parameter int SDR_REQ_ID_W = sdrc_bank_arb_pkg::SDR_REQ_ID_W,
    parameter int NB           = sdrc_bank_arb_pkg::NB_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    sdrc_bank_arb_if.slave bus
);
    import sdrc_bank_arb_pkg::*;

    arb_state_e state_reg, state_next;
    logic [1:0] rr_ptr_reg, rr_ptr_next;
    logic [1:0] lock_idx_reg, lock_idx_next;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       grant_req;
    logic [1:0] grant_idx;
    logic [1:0] sel_idx;

    logic [1:0]              cmd_arr   [NB];
    logic [11:0]             addr_arr  [NB];
    logic [REQ_BW-1:0]       len_arr   [NB];
    logic [SDR_REQ_ID_W-1:0] id_arr    [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            assign cmd_arr[gi]     = bus.b2a_cmd[2*gi +: 2];
            assign addr_arr[gi]    = bus.b2a_addr[12*gi +: 12];
            assign len_arr[gi]     = bus.b2a_len[REQ_BW*gi +: REQ_BW];
            assign id_arr[gi]      = bus.b2a_id[SDR_REQ_ID_W*gi +: SDR_REQ_ID_W];
            assign bus.a2b_ack[gi] = bus.x2a_ack && grant_req && (grant_idx == 2'(gi));
        end
    endgenerate

`ifdef SDRC_BANK_ARB_RDWR_PRIO_EN
    logic [NB-1:0] xfr_mask;
    logic          xfr_valid, oth_valid;
    logic [1:0]    xfr_idx, oth_idx;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_class
            assign xfr_mask[gi] = is_xfr_op(cmd_arr[gi]);
        end
    endgenerate

    // Both classes share rr_ptr so fairness carries across class changes.
    sdrc_rr_pick u_pick_xfr (
        .req   (bus.b2a_req & xfr_mask),
        .ptr   (rr_ptr_reg),
        .valid (xfr_valid),
        .idx   (xfr_idx)
    );

    sdrc_rr_pick u_pick_oth (
        .req   (bus.b2a_req & ~xfr_mask),
        .ptr   (rr_ptr_reg),
        .valid (oth_valid),
        .idx   (oth_idx)
    );

    assign pick_valid = xfr_valid | oth_valid;
    assign pick_idx   = xfr_valid ? xfr_idx : oth_idx;
`else
    sdrc_rr_pick u_pick (
        .req   (bus.b2a_req),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`endif

    always_comb begin
        grant_idx = pick_idx;
        grant_req = pick_valid && !bus.x2a_ref_pend;
        // A locked handshake keeps its bank and ignores refresh until it resolves.
        if (state_reg == ST_LOCK) begin
            grant_idx = lock_idx_reg;
            grant_req = bus.b2a_req[lock_idx_reg];
        end
        sel_idx = grant_req ? grant_idx : 2'd0;
    end

    assign bus.a2x_req   = grant_req;
    assign bus.a2x_ba    = sel_idx;
    assign bus.a2x_cmd   = cmd_arr[sel_idx];
    assign bus.a2x_addr  = addr_arr[sel_idx];
    assign bus.a2x_len   = len_arr[sel_idx];
    assign bus.a2x_id    = id_arr[sel_idx];
    assign bus.a2x_start = bus.b2a_start[sel_idx];
    assign bus.a2x_last  = bus.b2a_last[sel_idx];
    assign bus.a2x_wrap  = bus.b2a_wrap[sel_idx];

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        lock_idx_next = lock_idx_reg;
        if (bus.x2a_ack && grant_req) begin
            rr_ptr_next = grant_idx + 2'd1;
        end
        case (state_reg)
            ST_IDLE: begin
                if (grant_req && !bus.x2a_ack) begin
                    state_next    = ST_LOCK;
                    lock_idx_next = grant_idx;
                end
            end
            ST_LOCK: begin
                if (bus.x2a_ack || !bus.b2a_req[lock_idx_reg]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= 2'd0;
            lock_idx_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Directed and random checks of sdrc_bank_arb against a cycle-level behavioural model.
module tb_sdrc_bank_arb;
    import sdrc_bank_arb_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_err;

    // Reference model state: pointer, lock flag, locked bank.
    int   m_rr;
    bit   m_locked;
    int   m_lb;
    bit   e_req;
    int   e_idx;

    sdrc_bank_arb_if #(.REQ_BW(12), .SDR_REQ_ID_W(4), .NB(4)) bus ();

    sdrc_bank_arb #(.REQ_BW(12), .SDR_REQ_ID_W(4), .NB(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_from(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int winner(logic [3:0] r, logic [7:0] c, int p);
        logic [3:0] x;
        x = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (c[2*i +: 2] == OP_RD || c[2*i +: 2] == OP_WR) x[i] = r[i];
        end
`ifdef SDRC_BANK_ARB_RDWR_PRIO_EN
        if (x != 4'b0) return first_from(x, p);
`endif
        return first_from(r, p);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, then compare every output against the model.
    task automatic settle_check(input string tag);
        int         s;
        logic [3:0] e_ack;
        logic [32:0] e_pl;
        logic [32:0] o_pl;
        #1;
        if (m_locked) begin
            e_idx = m_lb;
            e_req = bus.b2a_req[m_lb];
        end else if (bus.x2a_ref_pend) begin
            e_idx = 0;
            e_req = 1'b0;
        end else begin
            e_idx = winner(bus.b2a_req, bus.b2a_cmd, m_rr);
            e_req = (e_idx >= 0);
            if (!e_req) e_idx = 0;
        end
        s     = e_req ? e_idx : 0;
        e_ack = (e_req && bus.x2a_ack) ? (4'b0001 << e_idx) : 4'b0000;
        e_pl  = {bus.b2a_cmd[2*s +: 2], bus.b2a_addr[12*s +: 12], bus.b2a_len[12*s +: 12],
                 bus.b2a_id[4*s +: 4], bus.b2a_start[s], bus.b2a_last[s], bus.b2a_wrap[s]};
        o_pl  = {bus.a2x_cmd, bus.a2x_addr, bus.a2x_len, bus.a2x_id,
                 bus.a2x_start, bus.a2x_last, bus.a2x_wrap};
        $display("%0t %s req=%b ack=%b ref=%b -> a2x_req=%b ba=%0d a2b_ack=%b",
                 $time, tag, bus.b2a_req, bus.x2a_ack, bus.x2a_ref_pend,
                 bus.a2x_req, bus.a2x_ba, bus.a2b_ack);
        chk({tag, ".a2x_req"}, 64'(bus.a2x_req), 64'(e_req));
        chk({tag, ".a2b_ack"}, 64'(bus.a2b_ack), 64'(e_ack));
        chk({tag, ".a2x_ba"},  64'(bus.a2x_ba),  64'(s));
        chk({tag, ".payload"}, 64'(o_pl),        64'(e_pl));
    endtask

    task automatic advance();
        if (!reset_n) begin
            m_rr = 0; m_locked = 1'b0; m_lb = 0;
        end else if (m_locked) begin
            if (bus.x2a_ack && e_req) m_rr = (e_idx + 1) % 4;
            if (bus.x2a_ack || !bus.b2a_req[m_lb]) m_locked = 1'b0;
        end else if (e_req) begin
            if (bus.x2a_ack) m_rr = (e_idx + 1) % 4;
            else begin
                m_locked = 1'b1;
                m_lb     = e_idx;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_payload();
        bus.b2a_cmd   = 8'($urandom);
        bus.b2a_addr  = 48'({$urandom, $urandom});
        bus.b2a_len   = 48'({$urandom, $urandom});
        bus.b2a_id    = 16'($urandom);
        bus.b2a_start = 4'($urandom);
        bus.b2a_last  = 4'($urandom);
        bus.b2a_wrap  = 4'($urandom);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; bus.b2a_req = 4'b0; bus.x2a_ack = 1'b0; bus.x2a_ref_pend = 1'b0;
        settle_check("reset");
        advance();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] cmd_v;
        int         exp_first;
        n_checks = 0; n_err = 0;
        m_rr = 0; m_locked = 1'b0; m_lb = 0; e_req = 1'b0; e_idx = 0;
        reset_n = 1'b0;
        bus.b2a_req = 4'b0; bus.x2a_ack = 1'b0; bus.x2a_ref_pend = 1'b0;
        rand_payload();
        @(negedge clk);
        do_reset();
        do_reset();

        // Full request with ack every cycle rotates 0,1,2,3,0.
        bus.b2a_req = 4'b1111; bus.x2a_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            settle_check("rot");
            chk("rot.seq", 64'(bus.a2x_ba), 64'(i % 4));
            advance();
        end

        // Lock held on bank 0 for three stalled cycles, then acked.
        do_reset();
        bus.b2a_req = 4'b0101; bus.x2a_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.x2a_ack = (i == 3);
            bus.b2a_req = (i == 1) ? 4'b1111 : 4'b0101;
            rand_payload();
            settle_check("lock0");
            chk("lock0.bank", 64'(bus.a2x_ba), 64'd0);
            advance();
        end
        bus.b2a_req = 4'b0101; bus.x2a_ack = 1'b0;
        settle_check("next2");
        chk("next2.bank", 64'(bus.a2x_ba), 64'd2);
        advance();

        // Bank 2 withdraws while locked: nothing presented, pointer stays at 1.
        bus.b2a_req = 4'b0001;
        settle_check("drop");
        chk("drop.req", 64'(bus.a2x_req), 64'd0);
        advance();
        bus.b2a_req = 4'b0101; bus.x2a_ack = 1'b1;
        settle_check("after_drop");
        chk("after_drop.bank", 64'(bus.a2x_ba), 64'd2);
        advance();

        // Pointer at 3: bank 3 wins, then pointer wraps to 0.
        bus.b2a_req = 4'b1001; bus.x2a_ack = 1'b1;
        settle_check("wrap3");
        chk("wrap3.bank", 64'(bus.a2x_ba), 64'd3);
        advance();
        settle_check("wrap0");
        chk("wrap0.bank", 64'(bus.a2x_ba), 64'd0);
        advance();

        // Refresh pending blocks new grants in IDLE.
        bus.b2a_req = 4'b0010; bus.x2a_ref_pend = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle_check("refpend");
            chk("refpend.req", 64'(bus.a2x_req), 64'd0);
            advance();
        end
        bus.x2a_ref_pend = 1'b0;
        settle_check("refclr");
        chk("refclr.ack", 64'(bus.a2b_ack), 64'b0010);
        advance();

        // Bank 0 PRE against bank 3 WR from pointer 0.
        do_reset();
        rand_payload();
        cmd_v = bus.b2a_cmd;
        cmd_v[1:0] = OP_PRE;
        cmd_v[7:6] = OP_WR;
        bus.b2a_cmd = cmd_v;
        bus.b2a_req = 4'b1001; bus.x2a_ack = 1'b1;
`ifdef SDRC_BANK_ARB_RDWR_PRIO_EN
        exp_first = 3;
`else
        exp_first = 0;
`endif
        settle_check("prio");
        chk("prio.bank", 64'(bus.a2x_ba), 64'(exp_first));
        advance();

        // Random traffic, including resets that may land mid-lock.
        for (int i = 0; i < 400; i++) begin
            reset_n          = ($urandom_range(0, 49) != 0);
            bus.b2a_req      = 4'($urandom);
            bus.x2a_ack      = ($urandom_range(0, 1) == 1);
            bus.x2a_ref_pend = ($urandom_range(0, 6) == 0);
            rand_payload();
            settle_check("rand");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
